// File: rtl/saida_bcd7seg.sv
// Display stage: 32-bit value to five active-low 7-segment digits via double-dabble.
// Define SAIDA_SINAL_EN for two's-complement input with a minus sign on saida5.
module saida_bcd7seg #(
    parameter int N_DISP = 5,
    parameter int N_ITER = 17
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [31:0] entrada,
    input  logic       controleOUT,
    output logic       ocupado,
    output logic [6:0] saida1,
    output logic [6:0] saida2,
    output logic [6:0] saida3,
    output logic [6:0] saida4,
    output logic [6:0] saida5
);

    localparam int BCD_W = 4 * N_DISP;
    localparam int CNT_W = $clog2(N_ITER);
    localparam logic [CNT_W-1:0] ULTIMO = CNT_W'(N_ITER - 1);

    localparam logic [6:0] SEG_BL = 7'b1111111;
    localparam logic [6:0] SEG_MENOS = 7'b0111111;
    localparam logic [6:0] SEG_E = 7'b0000110;
    localparam logic [6:0] SEG_ZERO = 7'b1000000;

    typedef enum logic [1:0] {OCIOSO, CONVERTE, ATUALIZA} estado_t;

    estado_t estado, proxEstado;

    logic [N_ITER-1:0] bin;
    logic [BCD_W-1:0] bcd, bcdAj;
    logic [CNT_W-1:0] cont;
    logic ovf;
    logic pend;
    logic [31:0] pendVal;

    logic carrega;
    logic [31:0] valCarga;
    logic [31:0] mag;
    logic ovfCarga;

    logic [6:0] disp1, disp2, disp3, disp4, disp5;
    logic [3:0] d0, d1, d2, d3, d4;

`ifdef SAIDA_SINAL_EN
    logic neg;
    logic negCarga;
`endif

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0: seg7 = 7'b1000000;
            4'd1: seg7 = 7'b1111001;
            4'd2: seg7 = 7'b0100100;
            4'd3: seg7 = 7'b0110000;
            4'd4: seg7 = 7'b0011001;
            4'd5: seg7 = 7'b0010010;
            4'd6: seg7 = 7'b0000010;
            4'd7: seg7 = 7'b1111000;
            4'd8: seg7 = 7'b0000000;
            4'd9: seg7 = 7'b0010000;
            default: seg7 = SEG_BL;
        endcase
    endfunction

    assign ocupado = (estado != OCIOSO);

    always_ff @(posedge clk) begin
        if (rst) estado <= OCIOSO;
        else estado <= proxEstado;
    end

    // A strobe in the ATUALIZA cycle takes priority over the stored pending value.
    always_comb begin
        proxEstado = estado;
        carrega = 1'b0;
        valCarga = entrada;
        unique case (estado)
            OCIOSO: begin
                if (controleOUT) begin
                    carrega = 1'b1;
                    proxEstado = CONVERTE;
                end
            end
            CONVERTE: begin
                if (cont == ULTIMO) proxEstado = ATUALIZA;
            end
            ATUALIZA: begin
                if (controleOUT || pend) begin
                    carrega = 1'b1;
                    valCarga = controleOUT ? entrada : pendVal;
                    proxEstado = CONVERTE;
                end else begin
                    proxEstado = OCIOSO;
                end
            end
            default: proxEstado = OCIOSO;
        endcase
    end

    always_comb begin
`ifdef SAIDA_SINAL_EN
        negCarga = valCarga[31];
        mag = negCarga ? (~valCarga + 32'd1) : valCarga;
        ovfCarga = mag > 32'd9999;
`else
        mag = valCarga;
        ovfCarga = mag > 32'd99999;
`endif
    end

    always_comb begin
        for (int i = 0; i < N_DISP; i++) begin
            bcdAj[4*i +: 4] = (bcd[4*i +: 4] >= 4'd5) ?
                bcd[4*i +: 4] + 4'd3 : bcd[4*i +: 4];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bin <= '0;
            bcd <= '0;
            cont <= '0;
            ovf <= 1'b0;
`ifdef SAIDA_SINAL_EN
            neg <= 1'b0;
`endif
        end else if (carrega) begin
            bin <= mag[N_ITER-1:0];
            bcd <= '0;
            cont <= '0;
            ovf <= ovfCarga;
`ifdef SAIDA_SINAL_EN
            neg <= negCarga;
`endif
        end else if (estado == CONVERTE) begin
            {bcd, bin} <= {bcdAj, bin} << 1;
            cont <= cont + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pend <= 1'b0;
            pendVal <= '0;
        end else if (estado == ATUALIZA) begin
            pend <= 1'b0;
        end else if (estado != OCIOSO && controleOUT) begin
            pend <= 1'b1;
            pendVal <= entrada;
        end
    end

    assign d0 = bcd[3:0];
    assign d1 = bcd[7:4];
    assign d2 = bcd[11:8];
    assign d3 = bcd[15:12];
    assign d4 = bcd[19:16];

    always_comb begin
        disp1 = seg7(d0);
`ifdef SAIDA_SINAL_EN
        disp5 = neg ? SEG_MENOS : SEG_BL;
        disp4 = (d3 != 0) ? seg7(d3) : SEG_BL;
        disp3 = ((d3 | d2) != 0) ? seg7(d2) : SEG_BL;
        disp2 = ((d3 | d2 | d1) != 0) ? seg7(d1) : SEG_BL;
`else
        disp5 = (d4 != 0) ? seg7(d4) : SEG_BL;
        disp4 = ((d4 | d3) != 0) ? seg7(d3) : SEG_BL;
        disp3 = ((d4 | d3 | d2) != 0) ? seg7(d2) : SEG_BL;
        disp2 = ((d4 | d3 | d2 | d1) != 0) ? seg7(d1) : SEG_BL;
`endif
        if (ovf) begin
            disp1 = SEG_E;
            disp2 = SEG_BL;
            disp3 = SEG_BL;
            disp4 = SEG_BL;
            disp5 = SEG_BL;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            saida1 <= SEG_ZERO;
            saida2 <= SEG_BL;
            saida3 <= SEG_BL;
            saida4 <= SEG_BL;
            saida5 <= SEG_BL;
        end else if (estado == ATUALIZA) begin
            saida1 <= disp1;
            saida2 <= disp2;
            saida3 <= disp3;
            saida4 <= disp4;
            saida5 <= disp5;
        end
    end

endmodule

// File: tb/tb_saida_bcd7seg.sv
// Scoreboard bench for saida_bcd7seg: expectations are queued per cycle
// when stimulus is driven and compared on the falling edge.
module tb_saida_bcd7seg;

    localparam logic [6:0] BL = 7'b1111111;
    localparam logic [6:0] SE = 7'b0000110;
    localparam logic [6:0] MENOS = 7'b0111111;
    localparam logic [6:0] ZERO = 7'b1000000;
    localparam logic [34:0] RST_DISP = {BL, BL, BL, BL, ZERO};

    logic clk = 1'b0;
    logic rst;
    logic controleOUT;
    logic [31:0] entrada;
    logic ocupado;
    logic [6:0] saida1, saida2, saida3, saida4, saida5;

    saida_bcd7seg dut (
        .clk(clk),
        .rst(rst),
        .entrada(entrada),
        .controleOUT(controleOUT),
        .ocupado(ocupado),
        .saida1(saida1),
        .saida2(saida2),
        .saida3(saida3),
        .saida4(saida4),
        .saida5(saida5)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int cyc;
        string tag;
        logic [34:0] disp;
        logic ocp;
    } exp_t;

    exp_t sb[$];
    exp_t atual;
    int nChecks = 0;
    int nPass = 0;
    logic [34:0] curDisp;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        nChecks++;
        if (got === exp) nPass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic void push(int c, string tag, logic [34:0] d, logic o);
        exp_t e;
        int i = 0;
        e.cyc = c;
        e.tag = tag;
        e.disp = d;
        e.ocp = o;
        while (i < sb.size() && sb[i].cyc <= c) i++;
        sb.insert(i, e);
    endfunction

    function automatic logic [6:0] seg(input logic [3:0] d);
        case (d)
            4'd0: seg = 7'b1000000;
            4'd1: seg = 7'b1111001;
            4'd2: seg = 7'b0100100;
            4'd3: seg = 7'b0110000;
            4'd4: seg = 7'b0011001;
            4'd5: seg = 7'b0010010;
            4'd6: seg = 7'b0000010;
            4'd7: seg = 7'b1111000;
            4'd8: seg = 7'b0000000;
            4'd9: seg = 7'b0010000;
            default: seg = 7'bxxxxxxx;
        endcase
    endfunction

    function automatic logic [34:0] expDisp(input logic [31:0] v);
        logic [6:0] s[5];
        logic [31:0] m;
        longint p;
        int nd;
        bit neg;
        neg = 1'b0;
`ifdef SAIDA_SINAL_EN
        neg = v[31];
        m = neg ? -v : v;
        nd = 4;
        if (m > 9999) return {BL, BL, BL, BL, SE};
`else
        m = v;
        nd = 5;
        if (m > 99999) return {BL, BL, BL, BL, SE};
`endif
        s[4] = BL;
        p = 1;
        for (int i = 0; i < nd; i++) begin
            s[i] = (i > 0 && m < p) ? BL : seg(4'((m / p) % 10));
            p *= 10;
        end
        if (neg) s[4] = MENOS;
        return {s[4], s[3], s[2], s[1], s[0]};
    endfunction

    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            atual = sb.pop_front();
            if (atual.cyc < cyc) begin
                check({atual.tag, "_missed"}, 64'(atual.cyc), 64'(cyc));
            end else begin
                check({atual.tag, "_disp"},
                      64'({saida5, saida4, saida3, saida2, saida1}),
                      64'(atual.disp));
                check({atual.tag, "_ocupado"}, 64'(ocupado), 64'(atual.ocp));
            end
        end
    end

    task automatic waitCyc(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic strobe(input logic [31:0] v);
        controleOUT = 1'b1;
        entrada = v;
        @(negedge clk);
        controleOUT = 1'b0;
        entrada = $urandom;
    endtask

    task automatic convert(input string tag, input logic [31:0] v);
        int t;
        logic [34:0] e;
        t = cyc + 1;
        e = expDisp(v);
        push(t, {tag, "_T"}, curDisp, 1'b1);
        push(t + 9, {tag, "_mid"}, curDisp, 1'b1);
        push(t + 17, {tag, "_T17"}, curDisp, 1'b1);
        push(t + 18, {tag, "_T18"}, e, 1'b0);
        curDisp = e;
        strobe(v);
        waitCyc(t + 20);
    endtask

    task automatic pendingTest();
        int t;
        logic [34:0] e5, e8, d;
        t = cyc + 1;
        e5 = expDisp(32'd5);
        e8 = expDisp(32'd8);
        for (int k = 0; k <= 36; k++) begin
            d = (k < 18) ? curDisp : ((k < 36) ? e5 : e8);
            push(t + k, $sformatf("pend%0d", k), d, k < 36);
        end
        strobe(32'd5);
        waitCyc(t + 2);
        strobe(32'd7);
        waitCyc(t + 17);
        strobe(32'd8);
        waitCyc(t + 40);
        curDisp = e8;
    endtask

    task automatic resetMidTest();
        int t;
        t = cyc + 1;
        push(t + 5, "rmid_busy", curDisp, 1'b1);
        push(t + 10, "rmid_rst", RST_DISP, 1'b0);
        push(t + 20, "rmid_after", RST_DISP, 1'b0);
        push(t + 40, "rmid_late", RST_DISP, 1'b0);
        strobe(32'd4321);
        waitCyc(t + 2);
        strobe(32'd1111);
        waitCyc(t + 9);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        waitCyc(t + 42);
        curDisp = RST_DISP;
    endtask

    task automatic resetStrobeTest();
        int t;
        t = cyc + 1;
        push(t + 1, "rststb_idle", RST_DISP, 1'b0);
        push(t + 19, "rststb_late", RST_DISP, 1'b0);
        rst = 1'b1;
        strobe(32'd9);
        rst = 1'b0;
        waitCyc(t + 21);
    endtask

    initial begin
        rst = 1'b1;
        controleOUT = 1'b0;
        entrada = '0;
        curDisp = RST_DISP;
        repeat (3) @(negedge clk);
        push(cyc + 1, "reset_hold", RST_DISP, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        push(cyc + 2, "reset_idle", RST_DISP, 1'b0);
        waitCyc(cyc + 3);
`ifdef SAIDA_SINAL_EN
        convert("neg42", 32'hFFFFFFD6);
        convert("pos42", 32'd42);
        convert("neg9999", -32'sd9999);
        convert("pos9999", 32'd9999);
        convert("ovf10000", 32'd10000);
        convert("ovfneg10000", -32'sd10000);
        convert("ovfmin", 32'h80000000);
        convert("zero", 32'd0);
`else
        convert("v1234", 32'd1234);
        convert("zero", 32'd0);
        convert("v99999", 32'd99999);
        convert("ovf100000", 32'd100000);
        convert("v10203", 32'd10203);
        convert("v7", 32'd7);
        convert("ovfmax", 32'hFFFFFFFF);
        convert("ovf2p17", 32'd131072);
        convert("v90000", 32'd90000);
`endif
        pendingTest();
        resetMidTest();
        resetStrobeTest();
        convert("final", 32'd1234);
        waitCyc(cyc + 5);
        if (sb.size() != 0) check("leftover", 64'(sb.size()), 64'd0);
        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
